// File: rtl/spi_pkg.sv
// spi_pkg -- definitions shared by the SPI controller block and its users.
//   spi_state_t    : controller FSM state encoding (IDLE, SETUP, XFER, HOLD)
//   CMD_TEST       : command whose peripheral response is RESP_TEST
//   CMD_READ_BASE  : read command; bits [5:4] select a byte of the peripheral
//                    configuration word
//   FRAME_BITS     : bits per transaction (command byte + response byte)
//   BIT_CNT_W      : width of the transferred-bit counter
package spi_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        XFER  = 2'd2,
        HOLD  = 2'd3
    } spi_state_t;

    localparam logic [7:0] CMD_TEST      = 8'h8F;
    localparam logic [7:0] RESP_TEST     = 8'hAA;
    localparam logic [7:0] CMD_READ_BASE = 8'h80;
    localparam int         READ_SEL_LSB  = 4;
    localparam int         READ_SEL_W    = 2;

    localparam int FRAME_BITS = 16;
    localparam int BIT_CNT_W  = 5;

endpackage

// File: rtl/spi_clk_div.sv
// spi_clk_div -- half-period tick generator for the SPI controller.
// Ports:
//   sclk  in  block clock
//   rst_n in  synchronous active-low reset
//   en    in  count enable; the counter reloads to CLK_DIV-1 on its rising edge
//   tick  out high on the last sclk cycle of every CLK_DIV-cycle half-period
module spi_clk_div #(
    parameter int CLK_DIV = 4
) (
    input  logic sclk,
    input  logic rst_n,
    input  logic en,
    output logic tick
);

    localparam int                CNT_W  = $clog2(CLK_DIV + 1);
    localparam logic [CNT_W-1:0]  RELOAD = CNT_W'(CLK_DIV - 1);

    logic [CNT_W-1:0] cnt_reg;
    logic             en_reg;

    always_ff @(posedge sclk) begin
        if (!rst_n) begin
            cnt_reg <= '0;
            en_reg  <= 1'b0;
        end else begin
            en_reg <= en;
            if (!en) begin
                cnt_reg <= '0;
            end else if (!en_reg || cnt_reg == '0) begin
                // Reload instead of decrementing through zero so the count
                // never wraps to all-ones between half-periods.
                cnt_reg <= RELOAD;
            end else begin
                cnt_reg <= cnt_reg - 1'b1;
            end
        end
    end

    // The enable-rise cycle is the reload cycle, so it never ticks; this makes
    // every half-period, including the first, exactly CLK_DIV cycles long.
    assign tick = en && en_reg && (cnt_reg == '0);

endmodule

// File: rtl/spi_controller.sv
// spi_controller -- single-transaction SPI master (mode 0, MSB first).
// Sends {tx_cmd, 8'h00} and returns the second received byte on rx_data.
// Ports:
//   sclk     in   block clock (rising edge)
//   rst_n    in   synchronous active-low reset
//   start    in   request; accepted only in IDLE when not in the done cycle
//   tx_cmd   in   command byte, captured at accept
//   busy     out  high from accept through the done cycle
//   done     out  one-cycle completion pulse
//   rx_data  out  last completed response byte
//   spi_ss_n out  peripheral select, active-low
//   spi_sck  out  SPI clock, idle low
//   spi_mosi out  controller-out data
//   spi_miso in   peripheral-out data
module spi_controller
    import spi_pkg::*;
#(
    parameter int CLK_DIV = 4
) (
    input  logic       sclk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [7:0] tx_cmd,
    output logic       busy,
    output logic       done,
    output logic [7:0] rx_data,
    output logic       spi_ss_n,
    output logic       spi_sck,
    output logic       spi_mosi,
    input  logic       spi_miso
);

    spi_state_t            state_reg;
    logic [15:0]           tx_shift_reg;
    logic [15:0]           rx_shift_reg;
    logic [BIT_CNT_W-1:0]  bit_cnt_reg;
    logic                  busy_reg;
    logic                  done_reg;
    logic                  ss_n_reg;
    logic                  sck_reg;
    logic [7:0]            rx_data_reg;

    logic accept;
    logic div_en;
    logic tick;

    // busy_reg is still high in the done cycle (state already IDLE), which is
    // what keeps a start in that cycle from being accepted.
    assign accept = (state_reg == IDLE) && !busy_reg && start;

    // Enabling the divider in the accepting cycle lets its reload happen on
    // the accepting edge, so SETUP is a full CLK_DIV cycles.
    assign div_en = accept || (state_reg != IDLE);

    spi_clk_div #(
        .CLK_DIV (CLK_DIV)
    ) u_clk_div (
        .sclk  (sclk),
        .rst_n (rst_n),
        .en    (div_en),
        .tick  (tick)
    );

    always_ff @(posedge sclk) begin
        if (!rst_n) begin
            state_reg    <= IDLE;
            tx_shift_reg <= '0;
            rx_shift_reg <= '0;
            bit_cnt_reg  <= '0;
            busy_reg     <= 1'b0;
            done_reg     <= 1'b0;
            ss_n_reg     <= 1'b1;
            sck_reg      <= 1'b0;
            rx_data_reg  <= 8'h00;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    sck_reg <= 1'b0;
                    if (accept) begin
                        state_reg    <= SETUP;
                        tx_shift_reg <= {tx_cmd, 8'h00};
                        rx_shift_reg <= '0;
                        bit_cnt_reg  <= '0;
                        busy_reg     <= 1'b1;
                        ss_n_reg     <= 1'b0;
                    end else begin
                        busy_reg <= 1'b0;
                        ss_n_reg <= 1'b1;
                    end
                end
                SETUP: begin
                    if (tick) begin
                        state_reg <= XFER;
                    end
                end
                XFER: begin
                    if (tick) begin
                        if (!sck_reg) begin
                            sck_reg <= 1'b1;
                        end else begin
                            // End of a high phase: sample MISO and advance
                            // MOSI together, so MOSI only moves as the next
                            // low phase begins.
                            sck_reg      <= 1'b0;
                            rx_shift_reg <= (rx_shift_reg << 1) | 16'(spi_miso);
                            tx_shift_reg <= tx_shift_reg << 1;
                            bit_cnt_reg  <= bit_cnt_reg + 1'b1;
                            if (bit_cnt_reg == BIT_CNT_W'(FRAME_BITS - 1)) begin
                                state_reg <= HOLD;
                            end
                        end
                    end
                end
                HOLD: begin
                    if (tick) begin
                        state_reg   <= IDLE;
                        done_reg    <= 1'b1;
                        rx_data_reg <= rx_shift_reg[7:0];
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign busy     = busy_reg;
    assign done     = done_reg;
    assign rx_data  = rx_data_reg;
    assign spi_ss_n = ss_n_reg;
    assign spi_sck  = sck_reg;
    // Zeros shift in behind the frame, so MOSI is 0 in HOLD and IDLE.
    assign spi_mosi = tx_shift_reg[15];

endmodule

// File: tb/tb_spi_controller.sv
// tb_spi_controller -- self-checking bench for spi_controller.
// Bus 0 runs CLK_DIV=4, bus 1 runs CLK_DIV=1; each has its own peripheral
// model that answers CMD_TEST and byte reads of a 32-bit configuration word.
`timescale 1ns/1ps
module tb_spi_controller;
    import spi_pkg::*;

    localparam logic [31:0] CONFIG_DATA = 32'h44332211;

    logic       sclk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start    [2];
    logic [7:0] tx_cmd   [2];
    logic       busy     [2];
    logic       done     [2];
    logic [7:0] rx_data  [2];
    logic       spi_ss_n [2];
    logic       spi_sck  [2];
    logic       spi_mosi [2];

    int n_cmp = 0;
    int n_bad = 0;

    always #5 sclk = ~sclk;

    // Peripheral's view of a command: how it builds its reply byte.
    function automatic logic [7:0] periph_resp(input logic [7:0] cmd);
        logic [31:0] sh;
        if (cmd == CMD_TEST) return RESP_TEST;
        if ((cmd & 8'hCF) == CMD_READ_BASE) begin
            sh = CONFIG_DATA >> (8 * int'(cmd[5:4]));
            return sh[7:0];
        end
        return 8'h00;
    endfunction

    for (genvar gi = 0; gi < 2; gi++) begin : g_bus
        logic        miso;
        logic [15:0] stream;
        logic [7:0]  resp;
        int          idx;
        int          ss_falls;
        int          done_cnt;

        spi_controller #(
            .CLK_DIV (gi == 0 ? 4 : 1)
        ) dut (
            .sclk     (sclk),
            .rst_n    (rst_n),
            .start    (start[gi]),
            .tx_cmd   (tx_cmd[gi]),
            .busy     (busy[gi]),
            .done     (done[gi]),
            .rx_data  (rx_data[gi]),
            .spi_ss_n (spi_ss_n[gi]),
            .spi_sck  (spi_sck[gi]),
            .spi_mosi (spi_mosi[gi]),
            .spi_miso (miso)
        );

        initial begin
            miso = 1'b0; stream = '0; resp = '0;
            idx = 0; ss_falls = 0; done_cnt = 0;
        end

        always @(negedge spi_ss_n[gi]) begin
            idx = 0; stream = '0; miso = 1'b0;
            ss_falls++;
        end

        always @(posedge spi_sck[gi]) begin
            stream = {stream[14:0], spi_mosi[gi]};
            idx++;
            if (idx == 8) resp = periph_resp(stream[7:0]);
        end

        // Mode 0: the peripheral changes MISO as SCK falls.
        always @(negedge spi_sck[gi]) begin
            if (idx >= 8 && idx < 16) miso = resp[15 - idx];
        end

        always @(posedge sclk) if (done[gi]) done_cnt++;
    end

    function automatic logic [15:0] stream_of(input int b);
        return (b == 0) ? g_bus[0].stream : g_bus[1].stream;
    endfunction
    function automatic int idx_of(input int b);
        return (b == 0) ? g_bus[0].idx : g_bus[1].idx;
    endfunction
    function automatic int falls_of(input int b);
        return (b == 0) ? g_bus[0].ss_falls : g_bus[1].ss_falls;
    endfunction
    function automatic int done_cnt_of(input int b);
        return (b == 0) ? g_bus[0].done_cnt : g_bus[1].done_cnt;
    endfunction
    function automatic int kdiv(input int b);
        return (b == 0) ? 4 : 1;
    endfunction

    // Reference: the expected reply from the peripheral's documented register
    // map, written as a byte table rather than a shift.
    function automatic logic [7:0] model_rx(input logic [7:0] cmd);
        logic [7:0] cfg_bytes [4];
        cfg_bytes[0] = 8'h11; cfg_bytes[1] = 8'h22;
        cfg_bytes[2] = 8'h33; cfg_bytes[3] = 8'h44;
        if (cmd == 8'h8F) return 8'hAA;
        if (cmd[7] && !cmd[6] && cmd[3:0] == 4'h0) return cfg_bytes[cmd[5:4]];
        return 8'h00;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Runs one transaction on bus b. Returns at the negedge of the done cycle.
    // With spam=1, start stays high for the whole transfer and the done cycle.
    task automatic do_txn(input int b, input logic [7:0] cmd, input bit spam,
                          output logic [7:0] rx, output int lat, output logic [15:0] bits);
        int n;
        int gaps;
        int falls0;
        falls0 = falls_of(b);
        @(negedge sclk);
        chk("idle_busy", 32'(busy[b]), 0);
        chk("idle_ss_n", 32'(spi_ss_n[b]), 1);
        start[b]  = 1'b1;
        tx_cmd[b] = cmd;
        @(negedge sclk);
        if (!spam) start[b] = 1'b0;
        tx_cmd[b] = ~cmd;
        n = 1;
        gaps = 0;
        while (!done[b] && n < 400) begin
            if (!busy[b] || spi_ss_n[b]) gaps++;
            @(negedge sclk);
            n++;
        end
        lat  = n;
        rx   = rx_data[b];
        bits = stream_of(b);
        chk("busy_ss_held", 32'(gaps), 0);
        chk("busy_in_done", 32'(busy[b]), 1);
        chk("ss_n_falls", 32'(falls_of(b) - falls0), 1);
        $display("txn bus=%0d cmd=%02h rx=%02h lat=%0d mosi=%04h", b, cmd, rx, lat, bits);
    endtask

    typedef struct {
        int         bus;
        logic [7:0] cmd;
        logic [7:0] exp_rx;
        int         exp_lat;
    } vec_t;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vec_t       vecs [9];
        logic [7:0] rx;
        logic [7:0] cmd;
        logic [15:0] bits;
        int         lat;
        int         b;
        int         n;
        int         d0;
        int         f0;

        vecs[0] = '{0, 8'h8F, 8'hAA, 137};
        vecs[1] = '{0, 8'h80, 8'h11, 137};
        vecs[2] = '{0, 8'h90, 8'h22, 137};
        vecs[3] = '{0, 8'hA0, 8'h33, 137};
        vecs[4] = '{0, 8'hB0, 8'h44, 137};
        vecs[5] = '{0, 8'h0F, 8'h00, 137};
        vecs[6] = '{1, 8'h8F, 8'hAA, 35};
        vecs[7] = '{1, 8'hB0, 8'h44, 35};
        vecs[8] = '{1, 8'h90, 8'h22, 35};

        for (int i = 0; i < 2; i++) begin
            start[i] = 1'b0;
            tx_cmd[i] = 8'h00;
        end

        // Reset state
        repeat (4) @(negedge sclk);
        for (int i = 0; i < 2; i++) begin
            chk("rst_ss_n", 32'(spi_ss_n[i]), 1);
            chk("rst_sck", 32'(spi_sck[i]), 0);
            chk("rst_mosi", 32'(spi_mosi[i]), 0);
            chk("rst_busy", 32'(busy[i]), 0);
            chk("rst_done", 32'(done[i]), 0);
            chk("rst_rx", 32'(rx_data[i]), 0);
        end
        rst_n = 1'b1;

        // Directed vectors; consecutive entries on a bus are back-to-back.
        for (int i = 0; i < 9; i++) begin
            do_txn(vecs[i].bus, vecs[i].cmd, 1'b0, rx, lat, bits);
            chk("vec_rx", 32'(rx), 32'(vecs[i].exp_rx));
            chk("vec_latency", 32'(lat), 32'(vecs[i].exp_lat));
            chk("vec_mosi_stream", 32'(bits), 32'({vecs[i].cmd, 8'h00}));
        end

        // Randomized commands against the reference model.
        for (int i = 0; i < 12; i++) begin
            b = i % 2;
            if ($urandom_range(0, 1) == 1)
                cmd = CMD_READ_BASE | 8'($urandom_range(0, 3) << 4);
            else
                cmd = 8'($urandom);
            do_txn(b, cmd, 1'b0, rx, lat, bits);
            chk("rand_rx", 32'(rx), 32'(model_rx(cmd)));
            chk("rand_latency", 32'(lat), 32'(34 * kdiv(b) + 1));
            chk("rand_mosi_stream", 32'(bits), 32'({cmd, 8'h00}));
        end

        // start held every cycle of a transfer, including the done cycle.
        d0 = done_cnt_of(0);
        do_txn(0, 8'hA0, 1'b1, rx, lat, bits);
        chk("spam_rx", 32'(rx), 32'h33);
        chk("spam_latency", 32'(lat), 137);
        f0 = falls_of(0);
        @(negedge sclk);
        chk("spam_done_cycle_ignored", 32'(busy[0]), 0);
        start[0] = 1'b0;
        repeat (10) @(negedge sclk);
        chk("spam_no_extra_ss", 32'(falls_of(0) - f0), 0);
        chk("spam_one_done", 32'(done_cnt_of(0) - d0), 1);

        // Reset in the middle of XFER (bit 9 low phase).
        do_txn(0, 8'h8F, 1'b0, rx, lat, bits);
        chk("pre_abort_rx", 32'(rx), 32'hAA);
        @(negedge sclk);
        start[0] = 1'b1;
        tx_cmd[0] = 8'hB0;
        @(negedge sclk);
        start[0] = 1'b0;
        n = 0;
        while (!(idx_of(0) == 9 && spi_sck[0] == 1'b0) && n < 400) begin
            @(negedge sclk);
            n++;
        end
        chk("abort_reached_bit9", 32'(idx_of(0)), 9);
        chk("abort_rx_kept", 32'(rx_data[0]), 32'hAA);
        d0 = done_cnt_of(0);
        rst_n = 1'b0;
        @(negedge sclk);
        chk("abort_ss_n", 32'(spi_ss_n[0]), 1);
        chk("abort_sck", 32'(spi_sck[0]), 0);
        chk("abort_busy", 32'(busy[0]), 0);
        chk("abort_rx_cleared", 32'(rx_data[0]), 0);
        @(negedge sclk);
        rst_n = 1'b1;
        repeat (200) @(negedge sclk);
        chk("abort_no_done", 32'(done_cnt_of(0) - d0), 0);
        chk("abort_rx_after", 32'(rx_data[0]), 0);
        chk("abort_idle_ss_n", 32'(spi_ss_n[0]), 1);

        // Recovery after abort.
        do_txn(0, 8'h90, 1'b0, rx, lat, bits);
        chk("recover_rx", 32'(rx), 32'h22);
        chk("recover_latency", 32'(lat), 137);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
